// File: rtl/cache_behavioural_model.sv
// ---------------------------------------------------------------------------
// cache_behavioural_model
//
// Purpose:
//   Dual-channel behavioural memory for core-level simulation. It holds a
//   byte-addressed instruction store (imem) and a byte-addressed data store
//   (dmem). Each store is served through its own request/busy/ready
//   handshake. Contents are preloaded hierarchically by the bench through the
//   arrays named imem and dmem. Reset never touches those arrays.
//
// Parameters:
//   LATENCY    cycles from request acceptance to the ready pulse (>= 1)
//   MEM_BYTES  bytes in each of imem and dmem (power of two)
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   imem_rd_en_i    instruction fetch request
//   imem_addr_i     fetch byte address
//   imem_busy_o     fetch channel cannot accept a request
//   imem_rdy_o      one-cycle pulse, imem_rd_data_o valid
//   imem_rd_data_o  fetched word, big-endian
//   dmem_rd_en_i    data load request
//   dmem_wr_en_i    data store request (wins over a simultaneous load)
//   dmem_addr_i     data byte address
//   dmem_wr_size_i  store size: 0 byte, 1 half, 2/3 word
//   dmem_wr_data_i  store data, LSB-aligned
//   dmem_busy_o     data channel cannot accept a request
//   dmem_rdy_o      one-cycle pulse, load data valid or store complete
//   dmem_rd_data_o  loaded word, little-endian
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cache_channel_fsm
//
// Purpose:
//   Handshake sequencer shared by both channels: IDLE -> WAIT -> IDLE.
//   A request is accepted in IDLE. Then LATENCY edges later the FSM returns
//   to IDLE and raises rdy for one cycle.
//
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   req       request from the requester
//   accept    comb: request is being accepted at the coming edge
//   done      comb: the coming edge raises rdy (the response edge)
//   busy      channel cannot accept a request
//   rdy       registered one-cycle ready pulse
// ---------------------------------------------------------------------------
module cache_channel_fsm #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic accept,
  output logic done,
  output logic busy,
  output logic rdy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          rdy_nxt;

  // State register. The ready pulse is registered here as well, so that it
  // appears in the cycle after the response edge. Reset aborts any
  // in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdy   <= rdy_nxt;
    end
  end

  // Next-state logic. On acceptance the counter is loaded with LATENCY-1.
  // WAIT then counts down. The edge that sees zero is the response edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdy_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req && rst) begin
          state_nxt = WAIT;
          cnt_nxt   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          rdy_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic. Busy is exactly the WAIT state. Busy therefore drops in
  // the same cycle that rdy is high, which allows back-to-back requests.
  // Acceptance is gated by rst so that nothing is committed while the bench
  // holds the model in reset.
  always_comb begin
    busy   = (state == WAIT);
    accept = (state == IDLE) && req && rst;
    done   = rdy_nxt;
  end

endmodule

module cache_behavioural_model #(
  parameter int LATENCY   = 1,
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_rd_en_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_busy_o,
  output logic        imem_rdy_o,
  output logic [31:0] imem_rd_data_o,
  input  logic        dmem_rd_en_i,
  input  logic        dmem_wr_en_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [1:0]  dmem_wr_size_i,
  input  logic [31:0] dmem_wr_data_i,
  output logic        dmem_busy_o,
  output logic        dmem_rdy_o,
  output logic [31:0] dmem_rd_data_o
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] imem [0:MEM_BYTES-1];
  logic [7:0] dmem [0:MEM_BYTES-1];

  logic [AW-1:0] i_idx [4];
  logic [AW-1:0] d_idx [4];

  logic          i_accept;
  logic          i_done;
  logic          d_accept;
  logic          d_done;
  logic          d_req;

  logic [31:0]   fetch_word;
  logic [31:0]   fetch_q;
  logic [31:0]   load_word;
  logic [31:0]   load_q;
  logic          is_load_q;
  logic [3:0]    wr_be;

  // Address bits above the store size are dropped by the modulo addressing.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr_i[31:AW], dmem_addr_i[31:AW]};

  // Byte k of an access uses (addr + k) mod MEM_BYTES. The AW-bit sum wraps
  // on its own, so unaligned and end-of-memory accesses need no special case.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      i_idx[k] = imem_addr_i[AW-1:0] + AW'(k);
      d_idx[k] = dmem_addr_i[AW-1:0] + AW'(k);
    end
  end

  // Fetch word is big-endian: the lowest address lands in bits 31:24.
  // Load word is little-endian: the lowest address lands in bits 7:0.
  always_comb begin
    fetch_word = {imem[i_idx[0]], imem[i_idx[1]], imem[i_idx[2]], imem[i_idx[3]]};
    load_word  = {dmem[d_idx[3]], dmem[d_idx[2]], dmem[d_idx[1]], dmem[d_idx[0]]};
  end

  // Store byte enables. Size 3 is treated as a full word.
  always_comb begin
    case (dmem_wr_size_i)
      2'd0:    wr_be = 4'b0001;
      2'd1:    wr_be = 4'b0011;
      default: wr_be = 4'b1111;
    endcase
  end

  // A load and a store raised together form one transaction. The store
  // wins and the load is dropped.
  assign d_req = dmem_rd_en_i | dmem_wr_en_i;

  cache_channel_fsm #(
    .LATENCY(LATENCY)
  ) u_imem_fsm (
    .clk    (clk),
    .rst    (rst),
    .req    (imem_rd_en_i),
    .accept (i_accept),
    .done   (i_done),
    .busy   (imem_busy_o),
    .rdy    (imem_rdy_o)
  );

  cache_channel_fsm #(
    .LATENCY(LATENCY)
  ) u_dmem_fsm (
    .clk    (clk),
    .rst    (rst),
    .req    (d_req),
    .accept (d_accept),
    .done   (d_done),
    .busy   (dmem_busy_o),
    .rdy    (dmem_rdy_o)
  );

  // Fetch path. The word is captured at the acceptance edge. It is exposed
  // on the output only at the response edge, so the output changes only
  // together with rdy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_q        <= '0;
      imem_rd_data_o <= '0;
    end else begin
      if (i_accept) begin
        fetch_q <= fetch_word;
      end
      if (i_done) begin
        imem_rd_data_o <= fetch_q;
      end
    end
  end

  // Load path. The transaction type is remembered so that a store response
  // leaves dmem_rd_data_o holding the previous load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q         <= '0;
      is_load_q      <= 1'b0;
      dmem_rd_data_o <= '0;
    end else begin
      if (d_accept) begin
        load_q    <= load_word;
        is_load_q <= dmem_rd_en_i & ~dmem_wr_en_i;
      end
      if (d_done && is_load_q) begin
        dmem_rd_data_o <= load_q;
      end
    end
  end

  // Store path. The bytes are committed at the acceptance edge, so address,
  // size and data need no separate holding registers. A reset arriving
  // during the wait does not undo the write. This array is deliberately
  // outside any reset so that preloaded contents survive reset.
  always_ff @(posedge clk) begin
    if (d_accept && dmem_wr_en_i) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          dmem[d_idx[k]] <= dmem_wr_data_i[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_behavioural_model.sv
// ---------------------------------------------------------------------------
// tb_cache_behavioural_model
//
// Purpose:
//   Self-checking bench for cache_behavioural_model. A byte-array reference
//   model of both stores predicts every fetch, load and store result. One
//   instance runs with LATENCY=1 for directed and random traffic. A second
//   instance runs with LATENCY=3 for the timing and ignored-request checks.
// ---------------------------------------------------------------------------
module tb_cache_behavioural_model;

  localparam int MEM_BYTES = 65536;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // LATENCY=1 instance
  logic        i_en;
  logic [31:0] i_addr;
  logic        i_busy;
  logic        i_rdy;
  logic [31:0] i_data;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata;
  logic        d_busy;
  logic        d_rdy;
  logic [31:0] d_rdata;

  // LATENCY=3 instance
  logic        s_i_en;
  logic [31:0] s_i_addr;
  logic        s_i_busy;
  logic        s_i_rdy;
  logic [31:0] s_i_data;
  logic        s_d_rd;
  logic        s_d_wr;
  logic [31:0] s_d_addr;
  logic [1:0]  s_d_size;
  logic [31:0] s_d_wdata;
  logic        s_d_busy;
  logic        s_d_rdy;
  logic [31:0] s_d_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_imem [MEM_BYTES];
  logic [7:0]  ref_dmem [MEM_BYTES];
  logic [31:0] last_load;

  cache_behavioural_model #(
    .LATENCY   (1),
    .MEM_BYTES (MEM_BYTES)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_en_i   (i_en),
    .imem_addr_i    (i_addr),
    .imem_busy_o    (i_busy),
    .imem_rdy_o     (i_rdy),
    .imem_rd_data_o (i_data),
    .dmem_rd_en_i   (d_rd),
    .dmem_wr_en_i   (d_wr),
    .dmem_addr_i    (d_addr),
    .dmem_wr_size_i (d_size),
    .dmem_wr_data_i (d_wdata),
    .dmem_busy_o    (d_busy),
    .dmem_rdy_o     (d_rdy),
    .dmem_rd_data_o (d_rdata)
  );

  cache_behavioural_model #(
    .LATENCY   (3),
    .MEM_BYTES (MEM_BYTES)
  ) u_dut3 (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_en_i   (s_i_en),
    .imem_addr_i    (s_i_addr),
    .imem_busy_o    (s_i_busy),
    .imem_rdy_o     (s_i_rdy),
    .imem_rd_data_o (s_i_data),
    .dmem_rd_en_i   (s_d_rd),
    .dmem_wr_en_i   (s_d_wr),
    .dmem_addr_i    (s_d_addr),
    .dmem_wr_size_i (s_d_size),
    .dmem_wr_data_i (s_d_wdata),
    .dmem_busy_o    (s_d_busy),
    .dmem_rdy_o     (s_d_rdy),
    .dmem_rd_data_o (s_d_rdata)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain byte arrays indexed modulo the store size.
  function automatic logic [31:0] ref_fetch(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      w = {w[23:0], ref_imem[(a + k) % MEM_BYTES]};
    end
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      w[8*k +: 8] = ref_dmem[(a + k) % MEM_BYTES];
    end
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] data);
    int n;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) begin
      ref_dmem[(a + k) % MEM_BYTES] = data[8*k +: 8];
    end
  endtask

  // Issues one fetch starting at the current negedge (channel free) and
  // returns at the negedge where rdy is seen, ready for a back-to-back call.
  task automatic do_fetch(input logic [31:0] addr);
    int          waited;
    int          busy_drop;
    logic [31:0] exp;
    exp       = ref_fetch(addr);
    i_en      = 1'b1;
    i_addr    = addr;
    @(posedge clk);
    #1;
    i_en      = 1'b0;
    i_addr    = $urandom;
    waited    = 0;
    busy_drop = 0;
    @(negedge clk);
    while (!i_rdy && waited < 20) begin
      if (!i_busy) busy_drop++;
      waited++;
      @(negedge clk);
    end
    check_output("fetch latency", waited, 1);
    check_output("fetch busy while waiting", busy_drop, 0);
    check_output("fetch busy at rdy", {31'b0, i_busy}, 0);
    check_output("fetch data", i_data, exp);
  endtask

  // Same pattern for the data channel; rd and wr may both be set.
  task automatic do_dmem(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata);
    int          waited;
    int          busy_drop;
    logic [31:0] exp;
    if (rd && !wr) begin
      last_load = ref_load(addr);
    end
    if (wr) begin
      ref_store(addr, size, wdata);
    end
    exp     = last_load;
    d_rd    = rd;
    d_wr    = wr;
    d_addr  = addr;
    d_size  = size;
    d_wdata = wdata;
    @(posedge clk);
    #1;
    d_rd      = 1'b0;
    d_wr      = 1'b0;
    d_addr    = $urandom;
    d_wdata   = $urandom;
    waited    = 0;
    busy_drop = 0;
    @(negedge clk);
    while (!d_rdy && waited < 20) begin
      if (!d_busy) busy_drop++;
      waited++;
      @(negedge clk);
    end
    check_output("dmem latency", waited, 1);
    check_output("dmem busy while waiting", busy_drop, 0);
    check_output("dmem busy at rdy", {31'b0, d_busy}, 0);
    check_output("dmem rd data", d_rdata, exp);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 63));
      1:       return 32'h0000_FFF8 + 32'($urandom_range(0, 7));
      2:       return $urandom;
      default: return {16'($urandom), 16'($urandom_range(0, 63))};
    endcase
  endfunction

  initial begin
    int          pulses;
    int          op;
    logic [31:0] word;

    rst       = 1'b0;
    i_en      = 1'b0;
    i_addr    = '0;
    d_rd      = 1'b0;
    d_wr      = 1'b0;
    d_addr    = '0;
    d_size    = '0;
    d_wdata   = '0;
    s_i_en    = 1'b0;
    s_i_addr  = '0;
    s_d_rd    = 1'b0;
    s_d_wr    = 1'b0;
    s_d_addr  = '0;
    s_d_size  = '0;
    s_d_wdata = '0;
    last_load = '0;

    // Preload both stores while reset is held.
    for (int i = 0; i < MEM_BYTES; i++) begin
      ref_imem[i] = 8'($urandom);
      ref_dmem[i] = 8'($urandom);
    end
    ref_imem[0] = 8'h12; ref_imem[1] = 8'h34; ref_imem[2] = 8'h56; ref_imem[3] = 8'h78;
    ref_dmem[16'h10] = 8'hEF; ref_dmem[16'h11] = 8'hBE;
    ref_dmem[16'h12] = 8'hAD; ref_dmem[16'h13] = 8'hDE;
    for (int i = 0; i < MEM_BYTES; i++) begin
      u_dut.imem[i]  = ref_imem[i];
      u_dut.dmem[i]  = ref_dmem[i];
      u_dut3.imem[i] = ref_imem[i];
    end

    repeat (2) @(negedge clk);
    check_output("reset imem busy", {31'b0, i_busy}, 0);
    check_output("reset imem rdy", {31'b0, i_rdy}, 0);
    check_output("reset imem data", i_data, 0);
    check_output("reset dmem busy", {31'b0, d_busy}, 0);
    check_output("reset dmem rdy", {31'b0, d_rdy}, 0);
    check_output("reset dmem data", d_rdata, 0);
    rst = 1'b1;

    // Directed traffic.
    do_fetch(32'h0);
    check_output("fetch 0 word", i_data, 32'h1234_5678);
    do_dmem(1'b1, 1'b0, 32'h10, 2'd0, 32'h0);
    check_output("load 0x10 word", d_rdata, 32'hDEAD_BEEF);
    do_dmem(1'b0, 1'b1, 32'h11, 2'd0, 32'h0000_00AA);
    do_dmem(1'b1, 1'b0, 32'h10, 2'd0, 32'h0);
    check_output("load after byte store", d_rdata, 32'hDEAD_AAEF);
    do_dmem(1'b0, 1'b1, 32'hFFFF, 2'd1, 32'h0000_1234);
    check_output("half store wrap hi byte", {24'b0, u_dut.dmem[16'hFFFF]}, 32'h34);
    check_output("half store wrap lo byte", {24'b0, u_dut.dmem[16'h0000]}, 32'h12);
    do_dmem(1'b1, 1'b0, 32'hFFFF, 2'd0, 32'h0);
    check_output("wrapped load low half", {16'b0, d_rdata[15:0]}, 32'h1234);
    do_dmem(1'b1, 1'b1, 32'h40, 2'd2, 32'hCAFE_F00D);
    word = {u_dut.dmem[16'h43], u_dut.dmem[16'h42], u_dut.dmem[16'h41], u_dut.dmem[16'h40]};
    check_output("rd+wr stored word", word, 32'hCAFE_F00D);
    @(negedge clk);
    check_output("rd+wr single rdy", {31'b0, d_rdy}, 0);

    // LATENCY=3: en held high through busy must not start a second fetch.
    s_i_en   = 1'b1;
    s_i_addr = 32'h0;
    @(posedge clk);
    #1;
    s_i_addr = 32'h4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("lat3 busy", {31'b0, s_i_busy}, 1);
      check_output("lat3 rdy early", {31'b0, s_i_rdy}, 0);
    end
    @(negedge clk);
    s_i_en = 1'b0;
    check_output("lat3 rdy", {31'b0, s_i_rdy}, 1);
    check_output("lat3 busy at rdy", {31'b0, s_i_busy}, 0);
    check_output("lat3 data", s_i_data, ref_fetch(32'h0));
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_i_rdy) pulses++;
    end
    check_output("lat3 extra rdy pulses", pulses, 0);

    // Reset mid-transaction: an accepted store stays written, outputs clear.
    d_wr    = 1'b1;
    d_addr  = 32'h80;
    d_size  = 2'd2;
    d_wdata = 32'h1122_3344;
    i_en    = 1'b1;
    i_addr  = 32'h8;
    @(posedge clk);
    #1;
    d_wr = 1'b0;
    i_en = 1'b0;
    ref_store(32'h80, 2'd2, 32'h1122_3344);
    rst = 1'b0;
    #1;
    check_output("abort imem busy", {31'b0, i_busy}, 0);
    check_output("abort dmem busy", {31'b0, d_busy}, 0);
    check_output("abort imem data", i_data, 0);
    check_output("abort dmem data", d_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    check_output("abort imem rdy", {31'b0, i_rdy}, 0);
    check_output("abort dmem rdy", {31'b0, d_rdy}, 0);
    rst       = 1'b1;
    last_load = '0;
    word = {u_dut.dmem[16'h83], u_dut.dmem[16'h82], u_dut.dmem[16'h81], u_dut.dmem[16'h80]};
    check_output("aborted store kept", word, 32'h1122_3344);
    word = {u_dut.dmem[16'h13], u_dut.dmem[16'h12], u_dut.dmem[16'h11], u_dut.dmem[16'h10]};
    check_output("dmem survives reset", word, ref_load(32'h10));
    word = {u_dut.imem[0], u_dut.imem[1], u_dut.imem[2], u_dut.imem[3]};
    check_output("imem survives reset", word, 32'h1234_5678);
    do_fetch(32'h8);
    do_dmem(1'b1, 1'b0, 32'h80, 2'd0, 32'h0);

    // Random concurrent traffic on both channels, issued back to back.
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      fork
        do_fetch(rand_addr());
        do_dmem(op < 4 || op > 7, op >= 4, rand_addr(), 2'($urandom_range(0, 3)), $urandom);
      join
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_behavioural_model.md
Name: cache_behavioural_model

Overview:
Behavioural, dual-channel memory model for core-level simulation. It holds a 64 KiB instruction store and a 64 KiB data store, both byte-addressed. It serves instruction fetches and data loads/stores through independent request/busy/ready handshakes. A testbench preloads its arrays hierarchically and compares data memory between two instances after a run.

Parameters:
- LATENCY, 1, cycles from request acceptance to the ready pulse; must be ≥1.
- MEM_BYTES, 65536, bytes in each of imem and dmem; must be a power of 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_rd_en_i  in  1  instruction fetch request.
- imem_addr_i  in  32  fetch byte address.
- imem_busy_o  out  1  fetch channel cannot accept a request.
- imem_rdy_o  out  1  one-cycle pulse; imem_rd_data_o is valid.
- imem_rd_data_o  out  32  fetched instruction word.
- dmem_rd_en_i  in  1  data load request.
- dmem_wr_en_i  in  1  data store request.
- dmem_addr_i  in  32  data byte address.
- dmem_wr_size_i  in  2  store size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- dmem_wr_data_i  in  32  store data, LSB-aligned.
- dmem_busy_o  out  1  data channel cannot accept a request.
- dmem_rdy_o  out  1  one-cycle pulse; load data valid or store complete.
- dmem_rd_data_o  out  32  loaded word.

Behaviour:
- Storage: byte arrays imem[0:MEM_BYTES-1] and dmem[0:MEM_BYTES-1], named exactly so for hierarchical access.
- Reset never clears or alters imem or dmem. Contents are written by the bench while rst is low.
- Reset (rst=0) drives busy_o=0, rdy_o=0 and rd_data_o=0 on both channels and aborts any in-flight request. An aborted store that was already accepted has already been written and is not undone.
- Addressing: index = addr mod MEM_BYTES. Multi-byte accesses wrap byte-by-byte, so byte k uses (addr+k) mod MEM_BYTES. No alignment requirement and no fault signalling.
- imem word is big-endian: data[31:24]=imem[a], [23:16]=imem[a+1], [15:8]=imem[a+2], [7:0]=imem[a+3].
- dmem is little-endian: data[7:0]=dmem[a] … data[31:24]=dmem[a+3].
- Loads always return the full 32-bit word. Size selection and sign extension are the requester's job.
- Stores write the low 1, 2 or 4 bytes of dmem_wr_data_i at a, a+1, … according to dmem_wr_size_i.
- Each channel has its own FSM, IDLE → WAIT → IDLE, and channels never interact.
- Acceptance: the request is sampled at a rising edge when en=1 and busy_o=0. Address, size and data are latched at that edge.
- Stores write dmem at the acceptance edge.
- Load data is read at the acceptance edge and registered.
- busy_o=1 from the acceptance edge until the edge that raises rdy_o. It returns to 0 in the same cycle rdy_o is 1, so back-to-back requests are possible.
- rdy_o=1 for exactly one cycle, LATENCY cycles after acceptance. With LATENCY=1 it is the cycle immediately following acceptance.
- rd_data_o updates only together with rdy_o on a read response and holds its value until the next read response.
- Simultaneous dmem_rd_en_i and dmem_wr_en_i: the store is performed, the load is ignored, and rdy_o pulses once; rd_data_o is unchanged.
- Requests raised while busy_o=1 are ignored; they are not queued.
- A request accepted in the same cycle rdy_o pulses, i.e. busy=0, starts a new transaction.
- Store and load to the same address on consecutive accepted requests: the load returns the stored value.
- A store is visible to a later imem fetch only if it targets imem. dmem stores never affect imem.

Test Plan:
- Preload imem[0..3]=12,34,56,78 during reset; fetch at 0 → imem_rdy_o pulses one cycle later with imem_rd_data_o=0x12345678; imem_busy_o=0 in that cycle.
- Preload dmem[0x10..0x13]=EF,BE,AD,DE; load at 0x10 → dmem_rd_data_o=0xDEADBEEF. Byte store 0xAA at 0x11, then load at 0x10 → 0xDEADAAEF.
- Half store 0x1234 at 0xFFFF → dmem[0xFFFF]=34, dmem[0x0000]=12; word load at 0xFFFF returns 0x??··1234 with wrapped bytes.
- LATENCY=3: request at edge N → busy high for cycles N..N+2, rdy high only after edge N+3. A second request during busy is ignored: exactly one rdy pulse.
- Assert rst low mid-transaction → busy/rdy/data=0 immediately; preloaded dmem and imem bytes are unchanged after reset release.
- rd_en and wr_en both high (word 0xCAFEF00D at 0x40) → dmem holds the new word, one rdy pulse, rd_data_o unchanged.
